// File: rtl/pc_fetch_pkg.sv
// Shared encodings, state type and reset/exception vectors for the fetch sequencer.
// PC_FETCH_EXC_EN keeps target bit[1:0] visible so misalignment can be trapped.
package pc_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JAL = 3'b011;
  localparam logic [2:0] NPC_JR  = 3'b100;

`ifdef PC_FETCH_EXC_EN
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TGT_MASK = 32'hFFFF_FFFC;
`endif

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_seq_npc_calc.sv
// Combinational redirect target from the decode-stage redir_* fields.
// PC_FETCH_EXC_EN leaves target[1:0] unmasked for the misalignment check.
module npc_calc
  import pc_fetch_pkg::*;
(
  input  logic [2:0]  i_slc,
  input  logic        i_zero,
  input  logic [31:0] i_base,
  input  logic [31:0] i_offset,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_jr,
  output logic        o_take,
  output logic [31:0] o_target
);

  logic [31:0] w_raw;

  // An untaken beq resumes at redir_base, which is the delay slot
  // already being fetched, so it leaves the sequential stream alone.
  always_comb begin
    w_raw  = i_base;
    o_take = 1'b0;
    unique case (1'b1)
      i_slc[2]: begin
        w_raw  = i_jr;
        o_take = 1'b1;
      end
      i_slc == NPC_BEQ: begin
        w_raw  = i_base + (i_offset << 2);
        o_take = i_zero;
      end
      (i_slc == NPC_J) || (i_slc == NPC_JAL): begin
        w_raw  = {i_base[31:28], i_imm26, 2'b00};
        o_take = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_target = w_raw & TGT_MASK;

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch-stage PC sequencer: PC register, imem handshake, redirect ordering.
// PC_FETCH_EXC_EN adds exc_req/adel and the exception vector path.
module pc_fetch_seq
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [2:0]  redir_slc,
  input  logic        redir_zero,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_offset,
  input  logic [25:0] redir_imm26,
  input  logic [31:0] redir_jr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        if_valid,
  output logic [31:0] if_pc
`ifdef PC_FETCH_EXC_EN
  ,
  input  logic        exc_req,
  output logic        adel
`endif
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend;
  logic         r_pend_v;

  logic         w_take;
  logic [31:0]  w_tgt;
  logic         w_redir;
  logic         w_done;
  logic         w_tgt_v;
  logic [31:0]  w_tgt_now;
  logic [31:0]  w_next;
  logic [31:0]  w_go_pc;
  logic         w_exc;
  logic         w_mis;

  npc_calc u_npc (
    .i_slc    (redir_slc),
    .i_zero   (redir_zero),
    .i_base   (redir_base),
    .i_offset (redir_offset),
    .i_imm26  (redir_imm26),
    .i_jr     (redir_jr),
    .o_take   (w_take),
    .o_target (w_tgt)
  );

  assign w_redir   = redir_valid & w_take;
  assign w_done    = (r_state == ST_REQ) & imem_ready;
  // A redirect arriving as the delay slot completes is used directly.
  assign w_tgt_v   = w_redir | r_pend_v;
  assign w_tgt_now = w_redir ? w_tgt : r_pend;

`ifdef PC_FETCH_EXC_EN
  logic r_exc_p;

  assign w_exc = exc_req | r_exc_p;
  assign w_mis = w_tgt_v & (w_tgt_now[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exc_p <= 1'b0;
      adel    <= 1'b0;
    end else begin
      adel <= w_done & ~w_exc & w_mis;
      if (w_done)
        r_exc_p <= 1'b0;
      else if (exc_req && (r_state == ST_REQ))
        r_exc_p <= 1'b1;
    end
  end
`else
  assign w_exc = 1'b0;
  assign w_mis = 1'b0;
`endif

  assign w_next  = (w_exc | w_mis) ? EXC_VEC :
                   w_tgt_v ? w_tgt_now : r_pc + 32'd4;
  assign w_go_pc = w_exc ? EXC_VEC : r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_pc     <= '0;
    end else begin
      if_valid <= 1'b0;
      if (w_redir && !w_exc) begin
        r_pend   <= w_tgt;
        r_pend_v <= 1'b1;
      end
      if (w_exc)
        r_pend_v <= 1'b0;
      unique case (r_state)
        ST_BOOT: begin
          r_state <= ST_IDLE;
          r_pc    <= w_go_pc;
        end
        ST_IDLE, ST_HOLD: begin
          r_pc <= w_go_pc;
          if (!stall) begin
            r_state   <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= w_go_pc;
          end
        end
        ST_REQ: begin
          if (imem_ready) begin
            if_valid  <= ~w_exc;
            if_pc     <= imem_addr;
            r_pc      <= w_next;
            imem_addr <= w_next;
            r_pend_v  <= 1'b0;
            if (stall) begin
              r_state  <= ST_HOLD;
              imem_req <= 1'b0;
            end
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed vector table, reset corner, random vs model.
// Exception-path sequence is compiled only with PC_FETCH_EXC_EN.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [2:0]  redir_slc;
  logic        redir_zero;
  logic [31:0] redir_base;
  logic [31:0] redir_offset;
  logic [25:0] redir_imm26;
  logic [31:0] redir_jr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        if_valid;
  logic [31:0] if_pc;
`ifdef PC_FETCH_EXC_EN
  logic        exc_req;
  logic        adel;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_seq dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_slc    (redir_slc),
    .redir_zero   (redir_zero),
    .redir_base   (redir_base),
    .redir_offset (redir_offset),
    .redir_imm26  (redir_imm26),
    .redir_jr     (redir_jr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .if_valid     (if_valid),
    .if_pc        (if_pc)
`ifdef PC_FETCH_EXC_EN
    ,
    .exc_req      (exc_req),
    .adel         (adel)
`endif
  );

  typedef struct {
    logic        st;
    logic        rd;
    logic        rv;
    logic [2:0]  slc;
    logic        z;
    logic [31:0] base;
    logic [31:0] off;
    logic [25:0] imm;
    logic [31:0] jr;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic rd, input logic rv,
                     input logic [2:0] slc, input logic z,
                     input logic [31:0] base, input logic [31:0] off,
                     input logic [25:0] imm, input logic [31:0] jr,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic ev, input logic [31:0] epc);
    vec_t v;
    v.st = st; v.rd = rd; v.rv = rv; v.slc = slc; v.z = z;
    v.base = base; v.off = off; v.imm = imm; v.jr = jr;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc;
    tbl.push_back(v);
  endtask

  task automatic seq_row(input logic [31:0] ea, input logic [31:0] ep);
    add(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 1, ea, 1, ep);
  endtask

  // Reference target: {taken, address} straight from the transfer rules.
  function automatic logic [32:0] ref_tgt(input logic [2:0] slc,
      input logic z, input logic [31:0] base, input logic [31:0] off,
      input logic [25:0] imm, input logic [31:0] jr);
    logic [31:0] t;
    if (slc == 3'd0) return 33'd0;
    if (slc >= 3'd4) t = jr;
    else if (slc == 3'd1) begin
      if (!z) return 33'd0;
      t = base + off * 4;
    end else t = (base & 32'hF000_0000) | ({6'd0, imm} * 4);
    return {1'b1, t & 32'hFFFF_FFFC};
  endfunction

  logic [31:0] m_pc, m_pend, addr_b, exp_pc;
  logic        m_pv, req_b, exp_v;
  logic [32:0] t;
  logic [15:0] o16;

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; redir_valid = 1'b0;
    redir_slc = 3'd0; redir_zero = 1'b0; redir_base = '0;
    redir_offset = '0; redir_imm26 = '0; redir_jr = '0;
`ifdef PC_FETCH_EXC_EN
    exc_req = 1'b0;
`endif

    add(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0);
    add(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3000, 0, 0);
    seq_row(32'h3004, 32'h3000);
    seq_row(32'h3008, 32'h3004);
    add(0, 1, 1, 3'b001, 1, 32'h3008, 32'h4, 0, 0, 1, 32'h3018, 1, 32'h3008);
    seq_row(32'h301C, 32'h3018);
    seq_row(32'h3020, 32'h301C);
    add(0, 1, 1, 3'b001, 0, 32'h3020, 32'h4, 0, 0, 1, 32'h3024, 1, 32'h3020);
    seq_row(32'h3028, 32'h3024);
    add(0, 0, 1, 3'b010, 0, 32'h3028, 0, 26'hC80, 0, 1, 32'h3028, 0, 32'h3024);
    add(0, 0, 1, 3'b100, 0, 32'h3028, 0, 0, 32'h3300, 1, 32'h3028, 0, 32'h3024);
    seq_row(32'h3300, 32'h3028);
    seq_row(32'h3304, 32'h3300);
    add(0, 0, 1, 3'b100, 0, 32'h3308, 0, 0, 32'h3100, 1, 32'h3304, 0, 32'h3300);
    add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3304, 0, 32'h3300);
    add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3304, 0, 32'h3300);
    seq_row(32'h3100, 32'h3304);
    seq_row(32'h3104, 32'h3100);
    add(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3104, 0, 32'h3100);
    add(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3104, 0, 32'h3100);
    add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h3108, 1, 32'h3104);
    add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h3108, 0, 32'h3104);
    add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h3108, 0, 32'h3104);
    add(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3108, 0, 32'h3104);
    seq_row(32'h310C, 32'h3108);
    add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 32'h3110, 1, 32'h310C);
    add(1, 1, 1, 3'b010, 0, 32'h3110, 0, 26'hD00, 0, 0, 32'h3110, 0, 32'h310C);
    add(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 1, 32'h3110, 0, 32'h310C);
    seq_row(32'h3400, 32'h3110);
    seq_row(32'h3404, 32'h3400);
    add(0, 1, 1, 3'b011, 0, 32'h3404, 0, 26'hD40, 0, 1, 32'h3500, 1, 32'h3404);
    seq_row(32'h3504, 32'h3500);
    add(0, 1, 1, 3'b000, 1, 32'h3504, 32'h40, 26'h3FFFFFF, 32'h5555,
        1, 32'h3508, 1, 32'h3504);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);

    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[i]) begin
      stall = tbl[i].st; imem_ready = tbl[i].rd;
      redir_valid = tbl[i].rv; redir_slc = tbl[i].slc;
      redir_zero = tbl[i].z; redir_base = tbl[i].base;
      redir_offset = tbl[i].off; redir_imm26 = tbl[i].imm;
      redir_jr = tbl[i].jr;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_req", i), imem_req, tbl[i].ereq);
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d_valid", i), if_valid, tbl[i].ev);
      chk($sformatf("row%0d_if_pc", i), if_pc, tbl[i].epc);
      @(negedge clk);
    end

    // Reset mid-request: request must drop before the next edge.
    stall = 1'b0; imem_ready = 1'b0; redir_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("amid_req", imem_req, 0);
    chk("amid_addr", imem_addr, 32'h3000);
    chk("amid_valid", if_valid, 0);
    @(negedge clk);
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("amid_hold_valid", if_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("boot_req", imem_req, 0);
    @(posedge clk);
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h3000);

    m_pc = 32'h3000; m_pv = 1'b0; m_pend = '0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 9) < 6);
      redir_valid = ($urandom_range(0, 5) == 0);
      redir_slc = 3'($urandom_range(0, 7));
      redir_zero = 1'($urandom_range(0, 1));
      redir_base = $urandom & 32'hFFFF_FFFC;
      o16 = 16'($urandom);
      redir_offset = {{16{o16[15]}}, o16};
      redir_imm26 = 26'($urandom);
`ifdef PC_FETCH_EXC_EN
      redir_jr = $urandom & 32'hFFFF_FFFC;
`else
      redir_jr = $urandom;
`endif
      req_b = imem_req;
      addr_b = imem_addr;
      if (redir_valid) begin
        t = ref_tgt(redir_slc, redir_zero, redir_base, redir_offset,
                    redir_imm26, redir_jr);
        if (t[32]) begin
          m_pend = t[31:0];
          m_pv = 1'b1;
        end
      end
      exp_v = 1'b0;
      exp_pc = '0;
      if (req_b && imem_ready) begin
        chk("rnd_fetch_addr", addr_b, m_pc);
        exp_v = 1'b1;
        exp_pc = m_pc;
        m_pc = m_pv ? m_pend : m_pc + 32'd4;
        m_pv = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rnd_if_valid", if_valid, exp_v);
      if (exp_v) chk("rnd_if_pc", if_pc, exp_pc);
      if (req_b && !imem_ready) begin
        chk("rnd_hold_req", imem_req, 1);
        chk("rnd_hold_addr", imem_addr, addr_b);
      end else begin
        chk("rnd_req", imem_req, !stall);
      end
    end

`ifdef PC_FETCH_EXC_EN
    @(negedge clk);
    redir_valid = 1'b0; stall = 1'b0; imem_ready = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    redir_valid = 1'b1; redir_slc = 3'b100; redir_jr = 32'h3102;
    @(posedge clk);
    #1;
    chk("adel_pulse", adel, 1);
    chk("adel_addr", imem_addr, 32'h4180);
    chk("adel_if_pc", if_pc, 32'h3008);
    @(negedge clk);
    redir_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("adel_clear", adel, 0);
    chk("exc_seq_addr", imem_addr, 32'h4184);
    @(negedge clk);
    imem_ready = 1'b0; exc_req = 1'b1;
    @(posedge clk);
    #1;
    chk("exc_hold_addr", imem_addr, 32'h4184);
    chk("exc_hold_valid", if_valid, 0);
    @(negedge clk);
    imem_ready = 1'b1; exc_req = 1'b0;
    @(posedge clk);
    #1;
    chk("exc_suppress", if_valid, 0);
    chk("exc_vec_addr", imem_addr, 32'h4180);
    @(posedge clk);
    #1;
    chk("exc_vec_valid", if_valid, 1);
    chk("exc_vec_if_pc", if_pc, 32'h4180);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
